// File: rtl/cbus_sram_responder_pkg.sv
// rtl/cbus_sram_responder_pkg.sv - cache-bus types, responder states and burst address helper
package cbus_sram_responder_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [7:0]  u8;

  // Bytes per beat is 1 << size; only affects address stepping.
  typedef enum logic [2:0] {
    MSIZE1, MSIZE2, MSIZE4, MSIZE8, MSIZE16, MSIZE32, MSIZE64, MSIZE128
  } msize_t;

  // Beat count minus one: MLEN1 is a single beat, MLEN256 is 256 beats.
  typedef logic [7:0] mlen_t;
  localparam mlen_t MLEN1   = 8'd0;
  localparam mlen_t MLEN2   = 8'd1;
  localparam mlen_t MLEN4   = 8'd3;
  localparam mlen_t MLEN8   = 8'd7;
  localparam mlen_t MLEN16  = 8'd15;
  localparam mlen_t MLEN256 = 8'd255;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'd0,
    BURST_INCR     = 2'd1,
    BURST_WRAP     = 2'd2,
    BURST_RESERVED = 2'd3
  } axi_burst_type_t;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} cbus_resp_state_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    mlen_t           len;
    axi_burst_type_t burst;
    logic [63:0]     data;
    logic [7:0]      strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  // Byte address of a given beat; RESERVED bursts step like INCR.
  function automatic addr_t cbus_beat_addr(addr_t addr, msize_t size, mlen_t len,
                                           axi_burst_type_t burst, u8 beat);
    addr_t stride;
    addr_t span;
    addr_t offs;
    addr_t result;
    stride = addr_t'(1) << size;
    span   = (addr_t'(len) + addr_t'(1)) * stride;
    offs   = addr + (addr_t'(beat) << size);
    case (burst)
      BURST_FIXED: result = addr;
      BURST_WRAP:  result = (addr & ~(span - addr_t'(1))) | (offs & (span - addr_t'(1)));
      default:     result = offs;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/cbus_sram_responder_if.sv
// rtl/cbus_sram_responder_if.sv - cache-bus request/response bundle
interface cbus_sram_responder_if;
  import cbus_sram_responder_pkg::*;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_sram_responder_beat_addr_gen.sv
// rtl/cbus_sram_responder_beat_addr_gen.sv - beat counter plus current/next burst beat addresses
module cbus_beat_addr_gen
  import cbus_sram_responder_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            advance,
  input  addr_t           addr,
  input  msize_t          size,
  input  mlen_t           len,
  input  axi_burst_type_t burst,
  output u8               beat,
  output logic            at_last,
  output addr_t           cur_addr,
  output addr_t           nxt_addr
);

  // Beat counter: cleared on acceptance, stops at len so it never wraps past the burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat <= '0;
    end else if (clear) begin
      beat <= '0;
    end else if (advance && (beat != len)) begin
      beat <= beat + 8'd1;
    end
  end

  assign at_last  = (beat == len);
  assign cur_addr = cbus_beat_addr(addr, size, len, burst, beat);
  // Lookahead lets the read path issue beat i+1 while returning beat i.
  assign nxt_addr = cbus_beat_addr(addr, size, len, burst, beat + 8'd1);

endmodule

// File: rtl/cbus_sram_responder.sv
// rtl/cbus_sram_responder.sv - cache-bus worker serving bursts from a 1-cycle synchronous SRAM
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  cbus_sram_responder_if.slave  cbus,
  output logic                  sram_en,
  output logic [7:0]            sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [63:0]           sram_wdata,
  input  logic [63:0]           sram_rdata
);

  cbus_resp_state_t state;
  cbus_resp_state_t state_next;
  addr_t            lat_addr;
  msize_t           lat_size;
  mlen_t            lat_len;
  axi_burst_type_t  lat_burst;
  logic             primed;
  logic             primed_next;
  logic             clear;
  logic             advance;
  u8                beat;
  logic             at_last;
  addr_t            cur_addr;
  addr_t            nxt_addr;
  addr_t            word_sel;
  cbus_resp_t       resp;
  logic             unused_addr_bits;

  cbus_beat_addr_gen u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .advance  (advance),
    .addr     (lat_addr),
    .size     (lat_size),
    .len      (lat_len),
    .burst    (lat_burst),
    .beat     (beat),
    .at_last  (at_last),
    .cur_addr (cur_addr),
    .nxt_addr (nxt_addr)
  );

  // State, read-pipeline fill flag and latched burst parameters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      primed    <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= MSIZE1;
      lat_len   <= '0;
      lat_burst <= BURST_FIXED;
    end else begin
      state  <= state_next;
      primed <= primed_next;
      if (state == IDLE && cbus.creq.valid) begin
        lat_addr  <= cbus.creq.addr;
        lat_size  <= cbus.creq.size;
        lat_len   <= cbus.creq.len;
        lat_burst <= cbus.creq.burst;
      end
    end
  end

  // Next state and all bus/SRAM outputs; everything idles at zero outside RD and WR.
  always_comb begin
    state_next  = state;
    primed_next = primed;
    clear       = 1'b0;
    advance     = 1'b0;
    resp        = '0;
    sram_en     = 1'b0;
    sram_we     = '0;
    sram_wdata  = '0;
    word_sel    = '0;
    case (state)
      IDLE: begin
        if (cbus.creq.valid) begin
          clear       = 1'b1;
          primed_next = 1'b0;
          state_next  = cbus.creq.is_write ? WR : RD;
        end
      end
      RD: begin
        if (!primed) begin
          sram_en     = 1'b1;
          word_sel    = cur_addr;
          primed_next = 1'b1;
        end else begin
          resp.ready = 1'b1;
          resp.data  = sram_rdata;
          advance    = 1'b1;
          if (at_last) begin
            resp.last  = 1'b1;
            state_next = DONE;
          end else begin
            sram_en  = 1'b1;
            word_sel = nxt_addr;
          end
        end
      end
      WR: begin
        resp.ready = 1'b1;
        sram_en    = 1'b1;
        sram_we    = cbus.creq.strobe;
        sram_wdata = cbus.creq.data;
        word_sel   = cur_addr;
        advance    = 1'b1;
        if (at_last) begin
          resp.last  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (!cbus.creq.valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sram_addr        = word_sel[ADDR_W+2:3];
  assign unused_addr_bits = ^{word_sel[31:ADDR_W+3], word_sel[2:0], beat};
  assign cbus.cresp       = resp;

endmodule
